alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares the single ALU instance among up to eight requesters, such as the execute stage, address generation and the flag-update path. It accepts one operation at a time through a valid/ready handshake and drives the registered operands and opcode into the ALU. It waits the ALU's fixed latency, captures result and flags, and returns them to the granted requester through a valid/ready response handshake.

## Interface
- NUM_REQ, 2: number of requesters; legal range 2..8.
- DATA_WIDTH, 32: operand and result width.
- OP_WIDTH, 4: ALU opcode width.
- ALU_LATENCY, 1: cycles from operands presented to result valid; must be ≥1.

- clk  in  1  system clock (master clock); all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_op  in  NUM_REQ*OP_WIDTH  flattened opcodes; requester i at [i*OP_WIDTH +: OP_WIDTH].
- req_a, req_b  in  NUM_REQ*DATA_WIDTH  flattened operands, same packing.
- alu_start  out  1  one-cycle pulse when new operands first presented.
- alu_op  out  OP_WIDTH  registered opcode to ALU.
- alu_a, alu_b  out  DATA_WIDTH  registered operands to ALU.
- alu_result  in  DATA_WIDTH  ALU result.
- alu_flags  in  4  ALU flags {N,Z,C,V}.
- resp_valid  out  NUM_REQ  one-hot response valid.
- resp_ready  in  NUM_REQ  per-requester response accept.
- resp_result  out  DATA_WIDTH  captured result (shared bus).
- resp_flags  out  4  captured flags.
- req_lock  in  NUM_REQ  grant lock (present only with ALU_ARB_LOCK_EN).

## Operation
- FSM states:
  - IDLE: requests are evaluated.
  - EXEC: waiting on the ALU.
  - RESP: response is being held.
- IDLE:
  - Search starts at rr_ptr and wraps modulo NUM_REQ; the winner is the first i with req_valid[i].
  - req_ready[winner] asserts combinationally in the same cycle. Only one bit of req_ready is ever high.
  - On the handshake, latch winner, op and operands into alu_op/alu_a/alu_b and go to EXEC.
  - rr_ptr ← (winner+1) mod NUM_REQ.
  - No valid request: stay in IDLE with all req_ready low.
- EXEC:
  - alu_start is high in the first EXEC cycle only.
  - A latency counter, of width clog2(ALU_LATENCY+1), counts from 1.
  - When the count equals ALU_LATENCY, sample alu_result/alu_flags into resp_result/resp_flags and go to RESP.
  - alu_* outputs stay stable throughout EXEC.
- RESP:
  - resp_valid[winner] is high; resp_result and resp_flags are stable.
  - On resp_valid & resp_ready go to IDLE.
  - resp_ready bits of non-granted requesters are ignored.
- req_ready is low in EXEC and RESP; no second operation is in flight.
- Requesters must hold req_valid/req_op/req_a/req_b stable until accepted. The arbiter does not check this.
- Reset, asynchronous, at any time, including mid-EXEC or mid-RESP:
  - State goes to IDLE and rr_ptr to 0.
  - req_ready, resp_valid, alu_start, alu_op, alu_a, alu_b, resp_result and resp_flags all go to 0.
  - An in-flight operation is dropped and no response is issued.

## Timing
- Grant handshake in cycle T0, then:
  - T1: alu_start, with operands valid on the ALU from T1.
  - End of T0+ALU_LATENCY: result sampled.
  - T0+ALU_LATENCY+1: resp_valid first high.
- Response accepted in cycle Tr: IDLE in Tr+1, and the next grant is possible in Tr+1.
- Minimum issue spacing is ALU_LATENCY+2 cycles with resp_ready held high.
- With all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0 with no starvation.
- rr_ptr at NUM_REQ-1 wraps to 0.

## Configuration
- ALU_ARB_LOCK_EN
- Defined:
  - The req_lock port exists.
  - If req_lock[winner] is high in the cycle the response is accepted, and req_valid[winner] is high in the next IDLE cycle, winner is granted again regardless of rr_ptr.
  - Used for chained carry operations such as 64-bit adds.
  - rr_ptr still advances to winner+1 after each grant.
  - If the locked requester is not valid, normal round-robin applies.
- Undefined: the port is absent and arbitration is pure round-robin.

## Test plan
- **Single request:** NUM_REQ=2, ALU_LATENCY=1, req 0 with op=ADD, a=5, b=7, ALU model returns 12 and flags 4'b0000.
  - Expected: req_ready[0] in T0, alu_start in T1, resp_valid[0] in T2 with resp_result=12.
- **Round-robin fairness:** all 3 of NUM_REQ=3 continuously valid, resp_ready high.
  - Expected: grant order 0,1,2,0,1,2, with consecutive grants 3 cycles apart.
- **Response backpressure:** resp_ready[1] held low for 5 cycles.
  - Expected: resp_valid[1], resp_result and resp_flags stable for 5 cycles; no req_ready to the other valid requester until the accept.
- **Latency and flags:** ALU_LATENCY=3, op with result 0xFFFFFFFF and flags N=1.
  - Expected: alu_* stable T1..T3, resp_valid in T4, resp_flags=4'b1000.
- **Reset mid-EXEC:** rst asserted in cycle T1 of an operation.
  - Expected: all outputs 0 immediately; no resp_valid after release; next grant goes to requester 0.
- **ALU_ARB_LOCK_EN:** req_lock[1]=1 with requesters 0 and 1 valid.
  - Expected: requester 1 granted twice consecutively; after req_lock[1] drops, requester 0 is granted next.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one fixed-latency ALU among NUM_REQ requesters.
// Define ALU_ARB_LOCK_EN to add req_lock, which re-grants a locked winner back-to-back.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*OP_WIDTH-1:0]      req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b,
  output logic                             alu_start,
  output logic [OP_WIDTH-1:0]              alu_op,
  output logic [DATA_WIDTH-1:0]            alu_a,
  output logic [DATA_WIDTH-1:0]            alu_b,
  input  logic [DATA_WIDTH-1:0]            alu_result,
  input  logic [3:0]                       alu_flags,
  output logic [NUM_REQ-1:0]               resp_valid,
  input  logic [NUM_REQ-1:0]               resp_ready,
  output logic [DATA_WIDTH-1:0]            resp_result,
  output logic [3:0]                       resp_flags
`ifdef ALU_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]               req_lock
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ALU_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, owner, win, idx;
  logic [IW:0] sum;
  logic [CW-1:0] cnt;
  logic found, lock_hit;
`ifdef ALU_ARB_LOCK_EN
  logic lock_pend;
  assign lock_hit = lock_pend && req_valid[owner];
`else
  assign lock_hit = 1'b0;
`endif
  // descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    win = owner;
    found = lock_hit;
    sum = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      idx = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
      if (!lock_hit && req_valid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign req_ready = (state == IDLE && found && !rst) ? NUM_REQ'(1) << win : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
      alu_start <= 1'b0;
      alu_op <= '0;
      alu_a <= '0;
      alu_b <= '0;
      resp_valid <= '0;
      resp_result <= '0;
      resp_flags <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_pend <= 1'b0;
`endif
    end else begin
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
`ifdef ALU_ARB_LOCK_EN
          lock_pend <= 1'b0;
`endif
          if (found) begin
            state <= EXEC;
            owner <= win;
            rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            cnt <= CW'(1);
            alu_start <= 1'b1;
            alu_op <= req_op[win*OP_WIDTH +: OP_WIDTH];
            alu_a <= req_a[win*DATA_WIDTH +: DATA_WIDTH];
            alu_b <= req_b[win*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        EXEC: begin
          if (cnt == CW'(ALU_LATENCY)) begin
            state <= RESP;
            resp_valid <= NUM_REQ'(1) << owner;
            resp_result <= alu_result;
            resp_flags <= alu_flags;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[owner]) begin
            state <= IDLE;
            resp_valid <= '0;
`ifdef ALU_ARB_LOCK_EN
            lock_pend <= req_lock[owner];
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scenarios against a queue-free round-robin reference model.
module tb_alu_arbiter;
  localparam int N = 3;
  localparam int L = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] vld = '0, rrdy = '1, lock = '0;
  logic [3:0] op [N];
  logic [31:0] a [N], b [N];
  logic [N*4-1:0] req_op;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0] req_ready, resp_valid;
  logic alu_start;
  logic [3:0] alu_op, alu_flags, resp_flags;
  logic [31:0] alu_a, alu_b, alu_result, resp_result;
  int total = 0, bad = 0, cyc = 0;
  int ptr = 0, lk_id = 0;
  bit lk_pend = 0;
  int w_g, x_g, w_tg, w_ts, w_tr, w_starts;
  bit w_to, w_oh, w_stable, w_leak;
  logic [3:0] w_op, x_op, w_fl;
  logic [31:0] w_a, w_b, x_a, x_b, w_res;
  logic [N-1:0] w_rv;

  function automatic logic [35:0] alu_fn(logic [3:0] o, logic [31:0] x, logic [31:0] y);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (o)
      4'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[31:0]; c = s[32]; v = (x[31] == y[31]) && (r[31] != x[31]); end
      4'd1: begin s = {1'b0, x} - {1'b0, y}; r = s[31:0]; c = s[32]; v = (x[31] != y[31]) && (r[31] != x[31]); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      default: r = x;
    endcase
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // ALU stand-in: the true result only appears in the L-th cycle after alu_start
  logic [3:0] age_q, age_cur;
  logic [35:0] alu_out;
  assign age_cur = alu_start ? 4'd1 : age_q;
  assign alu_out = alu_fn(alu_op, alu_a, alu_b);
  assign alu_result = (age_cur == L) ? alu_out[31:0] : 32'hDEADBEEF;
  assign alu_flags = (age_cur == L) ? alu_out[35:32] : 4'b0110;
  always_ff @(posedge clk or posedge rst)
    if (rst) age_q <= '0;
    else age_q <= (age_cur != 0 && age_cur < 15) ? age_cur + 4'd1 : 4'd0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_op[i*4 +: 4] = op[i];
      req_a[i*32 +: 32] = a[i];
      req_b[i*32 +: 32] = b[i];
    end
  end

  alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(32), .OP_WIDTH(4), .ALU_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(vld), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(rrdy), .resp_result(resp_result), .resp_flags(resp_flags)
`ifdef ALU_ARB_LOCK_EN
    , .req_lock(lock)
`endif
  );

  task automatic refresh(input int g, input bit keep);
    vld[g] = keep;
    op[g] = 4'($urandom_range(0, 5));
    a[g] = $urandom;
    b[g] = $urandom;
  endtask

  // Follows one transaction from grant to first resp_valid; the model predicts the winner.
  task automatic watch(input bit keep);
    int n;
    w_to = 0; w_stable = 1; w_leak = 0; w_starts = 0; w_ts = -1; w_g = -1; w_tg = -100; w_tr = -1;
    n = 0;
    @(negedge clk);
    while (req_ready == '0) begin
      n++;
      if (n > 40) begin w_to = 1; return; end
      @(negedge clk);
    end
    w_tg = cyc;
    w_oh = $onehot(req_ready);
    for (int i = 0; i < N; i++) if (req_ready[i]) w_g = i;
    x_g = (lk_pend && vld[lk_id]) ? lk_id : pick(vld, ptr);
    if (x_g < 0) x_g = 0;
    lk_pend = 0;
    ptr = (x_g + 1) % N;
    x_op = op[x_g]; x_a = a[x_g]; x_b = b[x_g];
    @(posedge clk); #1;
    refresh(w_g, keep);
    n = 0;
    @(negedge clk);
    w_ts = alu_start ? cyc : -1;
    w_op = alu_op; w_a = alu_a; w_b = alu_b;
    while (resp_valid == '0) begin
      if (alu_start) w_starts++;
      if (req_ready != '0) w_leak = 1;
      if (alu_op !== w_op || alu_a !== w_a || alu_b !== w_b) w_stable = 0;
      n++;
      if (n > 40) begin w_to = 1; return; end
      @(negedge clk);
    end
    w_tr = cyc; w_rv = resp_valid; w_res = resp_result; w_fl = resp_flags;
    lk_pend = lock[x_g];
    lk_id = x_g;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    vld = '1;
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, alu_start, alu_op, alu_a, alu_b, resp_result, resp_flags} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b start=%b op=%h a=%h b=%h res=%h fl=%h want all 0",
               req_ready, resp_valid, alu_start, alu_op, alu_a, alu_b, resp_result, resp_flags);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    vld = '0;
  endtask

  task automatic test_single;
    @(posedge clk); #1;
    vld = 3'b001; op[0] = 4'd0; a[0] = 32'd5; b[0] = 32'd7; rrdy = '1;
    watch(1'b0);
    total++; if (w_to) begin bad++; $display("FAIL single_timeout: got timeout want response"); end
    total++; if (w_g !== x_g) begin bad++; $display("FAIL single_grant: got %0d want %0d", w_g, x_g); end
    total++; if (w_ts !== w_tg + 1) begin bad++; $display("FAIL single_start: got %0d want %0d", w_ts, w_tg + 1); end
    total++; if ({w_op, w_a, w_b} !== {4'd0, 32'd5, 32'd7}) begin bad++; $display("FAIL single_alu_in: got %h/%0d/%0d want 0/5/7", w_op, w_a, w_b); end
    total++; if (w_tr !== w_tg + L + 1) begin bad++; $display("FAIL single_resp_time: got %0d want %0d", w_tr, w_tg + L + 1); end
    total++; if (w_res !== 32'd12 || w_fl !== 4'b0000) begin bad++; $display("FAIL single_result: got %0d/%b want 12/0000", w_res, w_fl); end
    total++; if (w_rv !== 3'b001) begin bad++; $display("FAIL single_resp_valid: got %b want 001", w_rv); end
  endtask

  task automatic test_round_robin;
    int prev;
    logic [35:0] e;
    prev = 0;
    @(posedge clk); #1;
    vld = '1; rrdy = '1;
    for (int t = 0; t < 6; t++) begin
      watch(1'b1);
      e = alu_fn(x_op, x_a, x_b);
      total++; if (w_to || w_g !== x_g || !w_oh) begin bad++; $display("FAIL rr_grant%0d: got %0d want %0d", t, w_g, x_g); end
      total++; if ({w_fl, w_res} !== e) begin bad++; $display("FAIL rr_result%0d: got %h want %h", t, {w_fl, w_res}, e); end
      if (t > 0) begin
        total++; if (w_tg - prev !== L + 2) begin bad++; $display("FAIL rr_spacing%0d: got %0d want %0d", t, w_tg - prev, L + 2); end
      end
      prev = w_tg;
    end
  endtask

  task automatic test_backpressure;
    int g;
    logic [35:0] e;
    @(posedge clk); #1;
    vld = 3'b011;
    g = pick(vld, ptr);
    rrdy = ~(N'(1) << g);
    watch(1'b0);
    e = alu_fn(x_op, x_a, x_b);
    total++; if (w_to || w_g !== x_g) begin bad++; $display("FAIL bp_grant: got %0d want %0d", w_g, x_g); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({resp_valid, resp_flags, resp_result, req_ready} !== {N'(1) << x_g, e, N'(0)}) begin
        bad++;
        $display("FAIL bp_hold%0d: got rv=%b res=%h fl=%b rdy=%b want rv=%b res=%h fl=%b rdy=0",
                 i, resp_valid, resp_result, resp_flags, req_ready, N'(1) << x_g, e[31:0], e[35:32]);
      end
    end
    @(posedge clk); #1;
    rrdy = '1;
    watch(1'b0);
    e = alu_fn(x_op, x_a, x_b);
    total++; if (w_to || w_g !== x_g) begin bad++; $display("FAIL bp_next_grant: got %0d want %0d", w_g, x_g); end
    total++; if ({w_fl, w_res} !== e) begin bad++; $display("FAIL bp_next_result: got %h want %h", {w_fl, w_res}, e); end
  endtask

  task automatic test_latency_flags;
    @(posedge clk); #1;
    vld = 3'b100; op[2] = 4'd3; a[2] = 32'hFFFFFFFF; b[2] = 32'd0; rrdy = '1;
    watch(1'b0);
    total++; if (w_to || w_tr !== w_tg + L + 1) begin bad++; $display("FAIL lat_resp_time: got %0d want %0d", w_tr, w_tg + L + 1); end
    total++; if (!w_stable || w_starts !== 1 || w_leak) begin bad++; $display("FAIL lat_exec: got stable=%0d starts=%0d leak=%0d want 1/1/0", w_stable, w_starts, w_leak); end
    total++; if ({w_op, w_a, w_b} !== {x_op, x_a, x_b}) begin bad++; $display("FAIL lat_alu_in: got %h/%h/%h want %h/%h/%h", w_op, w_a, w_b, x_op, x_a, x_b); end
    total++; if (w_res !== 32'hFFFFFFFF || w_fl !== 4'b1000) begin bad++; $display("FAIL lat_flags: got %h/%b want ffffffff/1000", w_res, w_fl); end
  endtask

  task automatic test_reset_mid;
    int n;
    bit seen;
    @(posedge clk); #1;
    vld = 3'b010; rrdy = '1;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 40) begin n++; @(negedge clk); end
    total++; if (n >= 40) begin bad++; $display("FAIL rstmid_grant: got no grant want grant"); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({req_ready, resp_valid, alu_start, alu_op, alu_a, alu_b, resp_result, resp_flags} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: got rdy=%b rv=%b start=%b op=%h a=%h b=%h want all 0",
               req_ready, resp_valid, alu_start, alu_op, alu_a, alu_b);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; vld = '0; ptr = 0; lk_pend = 0;
    seen = 0;
    for (int i = 0; i < L + 3; i++) begin
      @(negedge clk);
      if (resp_valid != '0) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL rstmid_no_resp: got resp_valid want none"); end
    @(posedge clk); #1;
    vld = '1;
    watch(1'b0);
    total++; if (w_to || w_g !== x_g) begin bad++; $display("FAIL rstmid_next_grant: got %0d want %0d", w_g, x_g); end
  endtask

  task automatic test_random;
    logic [35:0] e;
    rrdy = '1;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      vld = N'($urandom_range(1, (1 << N) - 1));
      watch(1'($urandom_range(0, 1)));
      e = alu_fn(x_op, x_a, x_b);
      total++; if (w_to || w_g !== x_g || !w_oh) begin bad++; $display("FAIL rand_grant%0d: got %0d want %0d", t, w_g, x_g); end
      total++; if ({w_fl, w_res} !== e || w_rv !== N'(1) << x_g) begin bad++; $display("FAIL rand_resp%0d: got %h rv=%b want %h", t, {w_fl, w_res}, w_rv, e); end
    end
  endtask

`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock;
    @(posedge clk); #1;
    vld = 3'b010; lock = 3'b010; rrdy = '1;
    watch(1'b1);
    total++; if (w_to || w_g !== x_g) begin bad++; $display("FAIL lock_first: got %0d want %0d", w_g, x_g); end
    @(posedge clk); #1;
    vld[0] = 1'b1;
    lock = '0;
    watch(1'b1);
    total++; if (w_to || w_g !== x_g) begin bad++; $display("FAIL lock_regrant: got %0d want %0d", w_g, x_g); end
    watch(1'b1);
    total++; if (w_to || w_g !== x_g) begin bad++; $display("FAIL lock_release: got %0d want %0d", w_g, x_g); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) refresh(i, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_latency_flags;
    test_reset_mid;
    test_random;
`ifdef ALU_ARB_LOCK_EN
    test_lock;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
